aes_encrypt_iterative: RTL and testbench
========================================

# aes_encrypt_iterative

Parametrised, iterative AES encryption engine covering AES-128, AES-192 and AES-256 from one RTL body. Block size is 128 bits and key length is selected by parameter. The engine expands the key into an internal round-key store one word per cycle, then runs one full round per cycle. Valid/ready handshakes on input and output let it sit behind a data source and ahead of a consumer, replacing the fully unrolled per-key-size encryptors where area matters more than throughput.

## Interface
Parameters:
- `KEY_BITS`, 192: key length, one of 128/192/256. Any other value is an elaboration error.
  - Derived `NK = KEY_BITS/32`; `NR = NK+6`; `NW = 4*(NR+1)`.

Ports:
- `CLK` in 1: the single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IN_VALID` in 1: `DATA`/`CIPHER_KEY` valid.
- `IN_READY` out 1: engine can accept. High only in IDLE.
- `DATA` in [0:127]: plaintext. Byte n is `DATA[8n:8n+7]`, column-major state (FIPS-197 order).
- `CIPHER_KEY` in [0:KEY_BITS-1]: key. Word i is `CIPHER_KEY[32i:32i+31]`.
- `OUT_VALID` out 1: `ENCRYPTED_DATA` valid.
- `OUT_READY` in 1: consumer accepts.
- `ENCRYPTED_DATA` out [0:127]: ciphertext. Registered and stable while `OUT_VALID` is high.

## Operation
- FSM states: IDLE, EXPAND, ROUND, DONE.
- IDLE
  - `IN_READY`=1.
  - On `IN_VALID`&`IN_READY`, latch `DATA`, load `CIPHER_KEY` into w[0..NK-1], set i=NK, set Rcon=0x01, go to EXPAND.
- EXPAND: each cycle writes w[i], then i++.
  - temp=w[i-1].
  - If i mod NK==0: temp=SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon=xtime(Rcon) (0x80→0x1b).
  - Else if NK==8 and i mod 8==4: temp=SubWord(temp).
  - w[i]=w[i-NK]^temp.
  - On the cycle writing w[NW-1]: state=data^w[0..3], round=1, go to ROUND.
- ROUND: each cycle state = ShiftRows(SubBytes(state)), then MixColumns (skipped when round==NR), then ^ w[4r..4r+3].
  - When round==NR, the result is loaded into `ENCRYPTED_DATA`, `OUT_VALID`=1, go to DONE.
- DONE: hold until `OUT_READY`=1, then `OUT_VALID`=0 and go to IDLE.
- `IN_VALID` is ignored outside IDLE. `DATA`/`CIPHER_KEY` need only be valid in the accept cycle.
- `OUT_READY` is ignored outside DONE.
- Round-key store: NW×32 registers. S-box logic is shared by 16 state S-boxes plus 4 key S-boxes.

## Timing
- Reset (any state, including mid-EXPAND/ROUND/DONE): FSM goes to IDLE; `IN_READY`=1, `OUT_VALID`=0, `ENCRYPTED_DATA`=0, key-cache valid=0. An in-flight block is discarded.
- Latency from accept edge to `OUT_VALID` rising:
  - (NW-NK) expansion cycles + NR round cycles.
  - Full-expansion totals: 50 (128), 58 (192), 66 (256).
- `IN_READY` rises in the cycle after the output handshake. The minimum initiation interval is latency+2.
- Output backpressure: `ENCRYPTED_DATA` is held indefinitely until `OUT_READY`.

## Configuration
- `AES_KEY_CACHE_EN` defined:
  - A 1-bit cache-valid flag and a KEY_BITS copy of the last expanded key are kept.
  - On accept with valid set and `CIPHER_KEY` equal to the stored copy, EXPAND is skipped. The accept edge loads state=`DATA`^`CIPHER_KEY[0:127]` with round=1 and goes straight to ROUND. Latency is NR cycles.
  - Valid is set on completion of EXPAND. It is cleared by reset and at entry to EXPAND, so a reset mid-expansion leaves no stale hit.
- `AES_KEY_CACHE_EN` undefined: every block runs full expansion. There is no comparator or copy register.

## Test plan
- KEY_BITS=128, key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a, `OUT_VALID` 50 cycles after accept.
- KEY_BITS=192, key 000102…17, same pt → dda97ca4864cdfe06eaf70a0ec0d7191, latency 58. KEY_BITS=256, key 000102…1f → 8ea2b7ca516745bfeafc49904b496089, latency 66.
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Hold `OUT_READY`=0 for 20 cycles: output stable, `IN_READY`=0 throughout.
- Back-to-back blocks with the same key:
  - With `AES_KEY_CACHE_EN`, the second block has latency NR (10/12/14) and the correct ciphertext.
  - Without the macro, full latency.
  - Changing one key bit forces full expansion.
- Assert `RST` for 1 cycle mid-EXPAND and again mid-ROUND: next cycle `IN_READY`=1, `OUT_VALID`=0, `ENCRYPTED_DATA`=0. The next vector completes correctly with full expansion latency.
- Toggle `IN_VALID` with garbage `DATA` while busy: no effect on the in-flight result.

Source files
------------

// File: rtl/aes_encrypt_iterative.sv
// aes_encrypt_iterative
//   Iterative AES-128/192/256 encryptor. Key is expanded into an NW x 32 round
//   key store one word per cycle, then one full round runs per cycle.
//   Optional macro AES_KEY_CACHE_EN: remember the last expanded key and skip
//   expansion when the next block arrives with the same key.
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   IN_VALID/IN_READY   input handshake; IN_READY high only while idle
//   DATA [0:127]        plaintext, byte n = DATA[8n:8n+7]
//   CIPHER_KEY          key, word i = CIPHER_KEY[32i:32i+31]
//   OUT_VALID/OUT_READY output handshake
//   ENCRYPTED_DATA      registered ciphertext, stable while OUT_VALID
module aes_encrypt_iterative #(
  parameter int KEY_BITS = 192
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [0:127]        DATA,
  input  logic [0:KEY_BITS-1] CIPHER_KEY,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [0:127]        ENCRYPTED_DATA
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;
  state_t state, nxt;

  // Internal vectors are descending: byte n lives at [127-8n -: 8].
  logic [127:0]          data_in, data_q, blk_q, enc_q, ss, mc, rk, rnd_out;
  logic [KEY_BITS-1:0]   key_in;
  logic [31:0]           w [NW];
  logic [5:0]            idx;
  logic [2:0]            kpos;   // idx mod NK, tracked incrementally
  logic [7:0]            rcon;
  logic [3:0]            round_q;
  logic [31:0]           prev, sw, w_new;
  logic                  hit, last_word, last_round;

  assign data_in        = DATA;
  assign key_in         = CIPHER_KEY;
  assign ENCRYPTED_DATA = enc_q;
  assign IN_READY       = (state == IDLE);
  assign OUT_VALID      = (state == DONE);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (a^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t, v;
    t = a;
    v = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      v = gmul(v, t);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

`ifdef AES_KEY_CACHE_EN
  logic                cache_vld;
  logic [KEY_BITS-1:0] cache_key;
  assign hit = cache_vld && (key_in == cache_key);
`else
  assign hit = 1'b0;
`endif

  // Key schedule step: the four key S-boxes are shared between the
  // RotWord/Rcon case and the extra AES-256 SubWord case.
  always_comb begin
    prev  = w[idx - 6'd1];
    sw    = sub_word((kpos == 3'd0) ? {prev[23:0], prev[31:24]} : prev);
    w_new = w[idx - 6'(NK)] ^ prev;
    if (kpos == 3'd0)
      w_new = w[idx - 6'(NK)] ^ sw ^ {rcon, 24'h0};
    else if (NK == 8 && kpos == 3'd4)
      w_new = w[idx - 6'(NK)] ^ sw;
  end

  assign last_word  = (idx == 6'(NW - 1));
  assign last_round = (round_q == 4'(NR));
  assign rk = {w[{round_q, 2'b00}], w[{round_q, 2'b01}],
               w[{round_q, 2'b10}], w[{round_q, 2'b11}]};
  assign ss      = sub_shift(blk_q);
  assign mc      = mix_columns(ss);
  assign rnd_out = (last_round ? ss : mc) ^ rk;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (IN_VALID)   nxt = hit ? ROUND : EXPAND;
      EXPAND:  if (last_word)  nxt = ROUND;
      ROUND:   if (last_round) nxt = DONE;
      DONE:    if (OUT_READY)  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      enc_q <= '0;
`ifdef AES_KEY_CACHE_EN
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (IN_VALID) begin
          data_q  <= data_in;
          for (int k = 0; k < NK; k++) w[k] <= key_in[KEY_BITS-1-32*k -: 32];
          idx     <= 6'(NK);
          kpos    <= 3'd0;
          rcon    <= 8'h01;
          round_q <= 4'd1;
`ifdef AES_KEY_CACHE_EN
          // Round keys w[4..] are still valid for this key: enter ROUND directly.
          blk_q <= data_in ^ key_in[KEY_BITS-1 -: 128];
          if (!hit) begin
            cache_vld <= 1'b0;
            cache_key <= key_in;
          end
`endif
        end
        EXPAND: begin
          w[idx] <= w_new;
          idx    <= idx + 6'd1;
          kpos   <= (kpos == 3'(NK - 1)) ? 3'd0 : kpos + 3'd1;
          if (kpos == 3'd0) rcon <= xtime(rcon);
          if (last_word) begin
            blk_q   <= data_q ^ {w[0], w[1], w[2], w[3]};
            round_q <= 4'd1;
`ifdef AES_KEY_CACHE_EN
            cache_vld <= 1'b1;
`endif
          end
        end
        ROUND: begin
          blk_q   <= rnd_out;
          round_q <= round_q + 4'd1;
          if (last_round) enc_q <= rnd_out;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Testbench for aes_encrypt_iterative: known-answer table, randomized blocks
// against a byte-array AES reference model, backpressure, reset and cache cases.
module tb_aes_encrypt_iterative;
  parameter int KB = 192;
  localparam int NK = KB / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          OUT_READY = 1'b0;
  logic [127:0]  DATA = '0;
  logic [KB-1:0] CIPHER_KEY = '0;
  logic          IN_READY, OUT_VALID;
  logic [127:0]  ENCRYPTED_DATA;

  aes_encrypt_iterative #(.KEY_BITS(KB)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA(DATA), .CIPHER_KEY(CIPHER_KEY), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ENCRYPTED_DATA(ENCRYPTED_DATA)
  );

  always #5 CLK = ~CLK;

  int           total = 0;
  int           passed = 0;
  logic [7:0]   sb [256];
  bit           cvalid = 1'b0;
  logic [255:0] ckey = '0;

  typedef struct {
    int           kb;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           hold;
  } vec_t;
  vec_t tbl [4];

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input int k);
    if (k == 1) return a;
    if (k == 2) return xt(a);
    return xt(a) ^ a;
  endfunction

  // Table built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_enc(input logic [255:0] kf, input logic [127:0] pt);
    logic [7:0]   ks [240];
    logic [7:0]   st [16];
    logic [7:0]   sh [16];
    logic [7:0]   t [4];
    logic [7:0]   t0, rc, acc;
    logic [127:0] res;
    int           coef [4];
    coef[0] = 2; coef[1] = 3; coef[2] = 1; coef[3] = 1;
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < 4 * NK; i++) ks[i] = kf[255-8*i -: 8];
    for (int i = NK; i < NW; i++) begin
      for (int j = 0; j < 4; j++) t[j] = ks[4*(i-1)+j];
      if (i % NK == 0) begin
        t0 = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[t0];
        rc = xt(rc);
      end else if (NK > 6 && i % NK == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
      end
      for (int j = 0; j < 4; j++) ks[4*i+j] = ks[4*(i-NK)+j] ^ t[j];
    end
    for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8] ^ ks[n];
    for (int r = 1; r <= NR; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          sh[4*c+row] = sb[st[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          if (r < NR) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gm(sh[4*c+j], coef[(j-row+4)%4]);
          end else begin
            acc = sh[4*c+row];
          end
          st[4*c+row] = acc ^ ks[16*r+4*c+row];
        end
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic start_block(input logic [255:0] kf, input logic [127:0] pt);
    int n;
    n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_before_accept", 128'(IN_READY), 128'd1);
    IN_VALID   = 1'b1;
    DATA       = pt;
    CIPHER_KEY = kf[255 -: KB];
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic run_block(input logic [255:0] kf, input logic [127:0] pt,
                           input logic [127:0] exp, input int hold, input string nm);
    int           cyc, exp_lat, bad;
    bit           hit, done;
    logic [255:0] g;
    hit = cvalid && (ckey[255 -: KB] == kf[255 -: KB]);
`ifdef AES_KEY_CACHE_EN
    exp_lat = hit ? NR : (NW - NK + NR);
`else
    exp_lat = NW - NK + NR;
`endif
    start_block(kf, pt);
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      if (cyc > 0 && OUT_VALID) done = 1'b1;
      else if (cyc >= 300) done = 1'b1;
      else begin
        // garbage while busy must be ignored
        g = rand256();
        IN_VALID   = 1'($urandom_range(0, 1));
        DATA       = g[127:0];
        CIPHER_KEY = g[255 -: KB];
        @(posedge CLK);
        cyc++;
        #1;
      end
    end
    IN_VALID = 1'b0;
    chk({nm, "_latency"}, 128'(cyc), 128'(exp_lat));
    chk({nm, "_ct"}, ENCRYPTED_DATA, exp);
    chk({nm, "_in_ready_busy"}, 128'(IN_READY), 128'd0);
    if (hold > 0) begin
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        @(posedge CLK);
        #1;
        if (ENCRYPTED_DATA !== exp || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) bad++;
      end
      chk({nm, "_hold_stable"}, 128'(bad), 128'd0);
    end
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    chk({nm, "_out_valid_after_hs"}, 128'(OUT_VALID), 128'd0);
    chk({nm, "_in_ready_after_hs"}, 128'(IN_READY), 128'd1);
    cvalid = 1'b1;
    ckey   = kf;
  endtask

  task automatic do_reset(input string nm);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk({nm, "_in_ready"}, 128'(IN_READY), 128'd1);
    chk({nm, "_out_valid"}, 128'(OUT_VALID), 128'd0);
    chk({nm, "_enc_data"}, ENCRYPTED_DATA, 128'd0);
    cvalid = 1'b0;
  endtask

  initial begin
    logic [255:0] k, k2;
    logic [127:0] pt;
    build_sbox();
    tbl[0] = '{128, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
               128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
    tbl[1] = '{192, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
               128'h00112233445566778899aabbccddeeff,
               128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0};
    tbl[2] = '{256, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff,
               128'h8ea2b7ca516745bfeafc49904b496089, 0};
    tbl[3] = '{128, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
               128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32, 20};

    repeat (3) @(posedge CLK);
    do_reset("reset_init");

    for (int i = 0; i < 4; i++)
      if (tbl[i].kb == KB)
        run_block(tbl[i].key, tbl[i].pt, tbl[i].ct, tbl[i].hold, $sformatf("kat%0d", i));

    // random blocks; odd iterations reuse the previous key
    k = rand256();
    for (int it = 0; it < 6; it++) begin
      if (it % 2 == 0) k = rand256();
      pt = rand256()[127:0];
      run_block(k, pt, ref_enc(k, pt), (it == 1) ? 20 : 0, $sformatf("rand%0d", it));
    end

    // same key twice, then one key bit flipped
    pt = rand256()[127:0];
    run_block(k, pt, ref_enc(k, pt), 0, "samekey");
    k2 = k ^ (256'b1 << (255 - $urandom_range(0, KB - 1)));
    pt = rand256()[127:0];
    run_block(k2, pt, ref_enc(k2, pt), 0, "flipbit");

    // reset mid-EXPAND, then mid-ROUND
    start_block(rand256(), rand256()[127:0]);
    repeat (5) @(posedge CLK);
    do_reset("reset_expand");
    start_block(rand256(), rand256()[127:0]);
    repeat (NW - NK + 3) @(posedge CLK);
    do_reset("reset_round");
    pt = rand256()[127:0];
    run_block(k2, pt, ref_enc(k2, pt), 0, "post_reset");
    pt = rand256()[127:0];
    run_block(k2, pt, ref_enc(k2, pt), 0, "post_reset_again");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
